muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Parametrised, multi-cycle HI/LO multiply/divide unit for the MIPS core's EX stage. It executes mult/multu/madd/maddu/msub/msubu with a fixed configurable latency and div/divu with an iterative radix-2 restoring divider. It owns the architectural HI/LO registers. New over the previous generation: `WIDTH`/latency parameters, a `flush` abort for exceptions, a `done` pulse, and defined divide-by-zero results.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; must be ≥ 4.
- `MUL_CYCLES`, 5, busy cycles for the multiply family; must be ≥ 1.

Ports (clock and reset first):
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `op` in 4: operation code. Encodings:
  - 0 idle, 1 mult, 2 multu, 3 div, 4 divu
  - 7 mthi, 8 mtlo
  - 9 madd, 10 maddu, 11 msub, 12 msubu
  - all other codes are treated as idle.
- `a` in WIDTH: rs operand (dividend; mthi/mtlo source).
- `b` in WIDTH: rt operand (divisor).
- `flush` in 1: abort the current or presented operation.
- `busy` out 1: operation in flight; the CPU stalls mfhi/mflo and new HI/LO ops while it is high.
- `done` out 1: one-cycle pulse in the first cycle new HI/LO are visible.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- **Reset** (all outputs and state): `hi`=0, `lo`=0, `busy`=0, `done`=0, FSM=IDLE, counter=0.
- **States:** IDLE, MUL, DIV_SETUP, DIV_ITER, DIV_FIX.
- **Accept:** in IDLE with `flush`=0, any of op 1,2,3,4,9–12 latches `a`, `b` and `op`.
  - Multiply ops go to MUL.
  - div/divu go to DIV_SETUP.
- **mthi/mtlo:** accepted only in IDLE with `flush`=0. Writes `a` to `hi`/`lo` at that edge. No busy, no done.
- **While busy:** `op` is ignored entirely, including mthi/mtlo.
- **MUL:** runs for `MUL_CYCLES` cycles, then writes the 2·WIDTH result to {hi,lo} and returns to IDLE.
  - mult/madd/msub: signed product.
  - multu/maddu/msubu: unsigned product.
  - madd/maddu: {hi,lo} + product. msub/msubu: {hi,lo} − product. Both use {hi,lo} as it stands at completion, modulo 2^(2·WIDTH).
- **DIV_SETUP (1 cycle):** take absolute values for div; zero the partial remainder.
- **DIV_ITER (WIDTH cycles):** one restoring step per cycle, MSB first.
- **DIV_FIX (1 cycle):** apply signs and write the results.
  - Quotient truncates toward zero. Remainder takes the dividend's sign. lo=quotient, hi=remainder.
- **Divide by zero:** lo = all ones, hi = `a` (signed and unsigned). No trap.
- **Signed overflow:** MIN / −1 gives lo=MIN, hi=0.
- **Flush:**
  - With `flush`=1 in any busy state, the FSM returns to IDLE at that edge. hi/lo are unchanged and no done pulse is produced.
  - `flush`=1 in IDLE suppresses both accept and mthi/mtlo.
- **Reset mid-operation:** the operation is abandoned and all outputs take their reset values.

## Timing
- Accept edge = end of cycle T.
- **Multiply family:**
  - `busy`=1 during cycles T+1..T+MUL_CYCLES.
  - hi/lo update at the end of cycle T+MUL_CYCLES.
  - `done`=1 and `busy`=0 in cycle T+MUL_CYCLES+1.
- **Divide:** latency L = WIDTH+2 (34 at WIDTH=32). `busy` is high during T+1..T+L; `done` is high in T+L+1.
- A new op may be accepted in the `done` cycle, which gives back-to-back issue with one idle-free gap.
- `busy` and `done` are never high in the same cycle. `done` is registered.
- mthi/mtlo: visible on `hi`/`lo` in cycle T+1.
- Flush in busy cycle F: `busy`=0 in F+1.

## Structure
- **Package `muldiv_pkg`:**
  - op code localparams: `OP_IDLE`, `OP_MULT` … `OP_MSUBU`, `OP_MTHI`, `OP_MTLO`;
  - state enum constants;
  - function `div_latency(WIDTH)`.
- **One sub-module, `div_core`:** iterative restoring divider with start/abort and a signed/unsigned select. Ports: quotient, remainder, valid.
- **Top level:** handles the FSM, the multiply latency counter, the multiply-accumulate datapath, and the HI/LO registers.

## Test plan
- mult a=−3, b=7 → `done` 6 cycles after the accept edge; hi=FFFFFFFF, lo=FFFFFFEB.
- mthi 1, mtlo 2, then madd a=2, b=3 → hi=1, lo=8; maddu a=FFFFFFFF, b=2 → hi=3, lo=6.
- div a=−7, b=2 → `busy` 34 cycles; lo=FFFFFFFD, hi=FFFFFFFF. divu a=7, b=0 → lo=FFFFFFFF, hi=7.
- div a=80000000, b=FFFFFFFF → lo=80000000, hi=0.
- Start divu 100/7, assert `flush` at busy cycle 10 → `busy`=0 next cycle, no `done`, hi/lo hold prior values. mthi presented with `flush`=1 → hi unchanged.
- Presenting mtlo while busy → ignored. Reset asserted mid-multiply → hi=lo=0, `busy`=0, `done`=0 next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the HI/LO multiply/divide unit:
//   - op code constants presented on the op bus
//   - FSM state encoding (also exported on the debug state field)
//   - helpers to classify op codes and to compute the divide latency
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam logic [3:0] OP_IDLE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MUL       = 3'd1,
        ST_DIV_SETUP = 3'd2,
        ST_DIV_ITER  = 3'd3,
        ST_DIV_FIX   = 3'd4
    } state_t;

    // Busy cycles of a divide: one setup, WIDTH iterations, one sign fix.
    function automatic int div_latency(input int width);
        return width + 2;
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_MADD) || (op == OP_MADDU) ||
               (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// -----------------------------------------------------------------------------
// muldiv_seq_if
// Request/result bus between the EX stage (master) and the HI/LO unit (slave).
//   op, a, b, flush : request from the CPU
//   busy, done      : status back to the CPU
//   hi, lo          : architectural HI/LO registers
//   state_dbg       : current unit FSM state, for observation only
//
// Handshake: a request is taken at a rising edge when the unit is idle
// (busy=0), flush=0 and op is a HI/LO op; op is ignored entirely while
// busy=1. A taken mult/div raises busy from the next cycle until the
// result is written; done then pulses for exactly one cycle, the first
// cycle in which the new hi/lo are visible, and a new op may be presented
// in that same cycle. mthi/mtlo never raise busy or done.
// -----------------------------------------------------------------------------
interface muldiv_seq_if import muldiv_pkg::*; #(
    parameter int WIDTH = 32
) ();

    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    state_t           state_dbg;

    modport master (
        output op, a, b, flush,
        input  busy, done, hi, lo, state_dbg
    );

    modport slave (
        input  op, a, b, flush,
        output busy, done, hi, lo, state_dbg
    );

endinterface

// File: rtl/muldiv_seq_div_core.sv
// -----------------------------------------------------------------------------
// div_core
// Iterative radix-2 restoring divider, one quotient bit per step, MSB first.
//   clk, reset : clock, synchronous active-high reset
//   start      : load operands (absolute values when is_signed), zero the
//                partial remainder
//   abort      : drop the operation in progress
//   step       : perform one restoring iteration
//   is_signed  : treat dividend/divisor as two's complement (sampled at start)
//   dividend, divisor : operands (sampled at start)
//   quotient, remainder : sign-corrected results, meaningful when valid=1
//   valid      : all WIDTH iterations completed since the last start
// Division by zero yields quotient all ones and remainder = dividend.
// -----------------------------------------------------------------------------
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             step,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);

    localparam int             CW    = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  STEPS = CW'(WIDTH);

    logic [WIDTH-1:0] quo_q;   // shifts dividend bits out, quotient bits in
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] dvd_q;   // original dividend for the divide-by-zero result
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             zero_q;
    logic             run_q;
    logic [CW-1:0]    cnt_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;

    assign a_neg = is_signed & dividend[WIDTH-1];
    assign b_neg = is_signed & divisor[WIDTH-1];

    // rem < divisor, so the shifted value is below 2*divisor and diff[WIDTH]
    // is exactly the borrow of the trial subtraction.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, dsr_q};

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            dvd_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            run_q     <= 1'b0;
            cnt_q     <= '0;
        end else if (start) begin
            quo_q     <= a_neg ? -dividend : dividend;
            dsr_q     <= b_neg ? -divisor : divisor;
            rem_q     <= '0;
            dvd_q     <= dividend;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            zero_q    <= (divisor == '0);
            run_q     <= 1'b1;
            cnt_q     <= '0;
        end else if (step && run_q && (cnt_q != STEPS)) begin
            if (!diff[WIDTH]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= rem_shift[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // MIN / -1 needs no special case: |MIN| fits unsigned, and negating the
    // unsigned quotient 2^(WIDTH-1) wraps back to MIN with remainder 0.
    assign quotient  = zero_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
    assign remainder = zero_q ? dvd_q : (neg_rem_q ? -rem_q : rem_q);
    assign valid     = run_q && (cnt_q == STEPS);

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Multi-cycle HI/LO multiply/divide unit for the EX stage. Owns HI/LO.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : muldiv_seq_if slave port (op, a, b, flush in; busy, done,
//           hi, lo, state_dbg out)
// Multiply family completes after MUL_CYCLES busy cycles; div/divu use
// div_core and complete after WIDTH+2 busy cycles. flush during busy
// abandons the operation without touching hi/lo.
// -----------------------------------------------------------------------------
module muldiv_seq import muldiv_pkg::*; #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input logic         clk,
    input logic         reset,
    muldiv_seq_if.slave bus
);

    localparam int              DIV_LAT   = div_latency(WIDTH);
    localparam int              CNT_MAX   = (MUL_CYCLES > DIV_LAT) ? MUL_CYCLES : DIV_LAT;
    localparam int              CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    // ---------------- multiply / accumulate datapath ----------------
    // Operands are extended to 2*WIDTH so a single truncated product gives
    // the correct signed or unsigned result modulo 2^(2*WIDTH).
    logic               mul_signed;
    logic [2*WIDTH-1:0] ext_a, ext_b, product, acc, mul_result;

    assign mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    assign ext_a      = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b      = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign product    = ext_a * ext_b;
    assign acc        = {hi_q, lo_q};

    always_comb begin
        mul_result = product;
        if ((op_q == OP_MADD) || (op_q == OP_MADDU)) begin
            mul_result = acc + product;
        end else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU)) begin
            mul_result = acc - product;
        end
    end

    // ---------------- divider ----------------
    logic             div_start, div_step, div_abort, div_valid;
    logic [WIDTH-1:0] div_quo, div_rem;

    assign div_start = (state_q == ST_DIV_SETUP) && !bus.flush;
    assign div_step  = (state_q == ST_DIV_ITER) && !bus.flush;
    assign div_abort = (state_q != ST_IDLE) && bus.flush;

    div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .abort     (div_abort),
        .step      (div_step),
        .is_signed (op_q == OP_DIV),
        .dividend  (a_q),
        .divisor   (b_q),
        .quotient  (div_quo),
        .remainder (div_rem),
        .valid     (div_valid)
    );

    // ---------------- FSM: next state / datapath control ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!bus.flush) begin
                    if (is_mul_op(bus.op) || is_div_op(bus.op)) begin
                        op_d    = bus.op;
                        a_d     = bus.a;
                        b_d     = bus.b;
                        cnt_d   = '0;
                        state_d = is_mul_op(bus.op) ? ST_MUL : ST_DIV_SETUP;
                    end else if (bus.op == OP_MTHI) begin
                        hi_d = bus.a;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d = bus.a;
                    end
                end
            end

            ST_MUL: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    hi_d    = mul_result[2*WIDTH-1:WIDTH];
                    lo_d    = mul_result[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DIV_SETUP: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_DIV_ITER;
                end
            end

            ST_DIV_ITER: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == ITER_LAST) begin
                    state_d = ST_DIV_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DIV_FIX: begin
                state_d = ST_IDLE;
                if (!bus.flush && div_valid) begin
                    hi_d   = div_rem;
                    lo_d   = div_quo;
                    done_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
// Directed bench for muldiv_seq at WIDTH=32, MUL_CYCLES=5. Inputs change on
// the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int WIDTH      = 32;
    localparam int MUL_CYCLES = 5;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    muldiv_seq_if #(.WIDTH(WIDTH)) bus ();

    muldiv_seq #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- comparison helper ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // busy and done must never overlap
    always @(negedge clk) begin
        if (reset === 1'b0) check("busy_done_exclusive", {63'd0, bus.busy & bus.done}, 64'd0);
    end

    // ---------------- driver tasks ----------------
    // mthi/mtlo style single-cycle request, optionally with flush
    task automatic move_op(input logic [3:0] o, input logic [31:0] aa, input logic fl);
        @(negedge clk);
        bus.op = o; bus.a = aa; bus.flush = fl;
        @(negedge clk);
        bus.op = OP_IDLE; bus.flush = 1'b0;
        check("move_busy", {63'd0, bus.busy}, 64'd0);
        check("move_done", {63'd0, bus.done}, 64'd0);
    endtask

    // issue a multi-cycle op and wait (bounded) for done
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input int exp_busy);
        int n;
        bit seen_done;
        @(negedge clk);
        bus.op = o; bus.a = aa; bus.b = bb;
        @(negedge clk);
        bus.op = OP_IDLE;
        n = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.done) begin
                seen_done = 1'b1;
                break;
            end
            if (!bus.busy) break;
            n++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 64'(n), 64'(exp_busy));
        check({tag, " done_seen"}, {63'd0, seen_done}, 64'd1);
        check({tag, " busy_at_done"}, {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] h, input logic [31:0] l);
        check({tag, " hi"}, {32'd0, bus.hi}, {32'd0, h});
        check({tag, " lo"}, {32'd0, bus.lo}, {32'd0, l});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n_done;
        bus.op = OP_IDLE; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_hilo("reset", 32'h0, 32'h0);
        check("reset busy", {63'd0, bus.busy}, 64'd0);
        check("reset done", {63'd0, bus.done}, 64'd0);
        check("reset state", {61'd0, bus.state_dbg}, {61'd0, ST_IDLE});
        reset = 1'b0;

        // signed multiply
        run_op("mult -3*7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 5);
        check_hilo("mult -3*7", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // moves and multiply-accumulate
        move_op(OP_MTHI, 32'd1, 1'b0);
        check("mthi 1", {32'd0, bus.hi}, 64'd1);
        move_op(OP_MTLO, 32'd2, 1'b0);
        check_hilo("mtlo 2", 32'd1, 32'd2);
        run_op("madd 2*3", OP_MADD, 32'd2, 32'd3, 5);
        check_hilo("madd 2*3", 32'd1, 32'd8);
        run_op("maddu", OP_MADDU, 32'hFFFF_FFFF, 32'd2, 5);
        check_hilo("maddu", 32'd3, 32'd6);

        run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        check_hilo("multu max", 32'hFFFF_FFFE, 32'h0000_0001);

        move_op(OP_MTHI, 32'd0, 1'b0);
        move_op(OP_MTLO, 32'd10, 1'b0);
        run_op("msub 3*4", OP_MSUB, 32'd3, 32'd4, 5);
        check_hilo("msub 3*4", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("msubu 2*3", OP_MSUBU, 32'd2, 32'd3, 5);
        check_hilo("msubu 2*3", 32'hFFFF_FFFF, 32'hFFFF_FFF8);

        // divides
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34);
        check_hilo("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 34);
        check_hilo("div 7/-2", 32'd1, 32'hFFFF_FFFD);
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 34);
        check_hilo("divu 100/7", 32'd2, 32'd14);
        run_op("divu 7/0", OP_DIVU, 32'd7, 32'd0, 34);
        check_hilo("divu 7/0", 32'd7, 32'hFFFF_FFFF);
        run_op("div -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 34);
        check_hilo("div -5/0", 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34);
        check_hilo("div min/-1", 32'd0, 32'h8000_0000);
        run_op("divu max/10", OP_DIVU, 32'hFFFF_FFFF, 32'd10, 34);
        check_hilo("divu max/10", 32'd5, 32'h1999_9999);

        // flush in busy cycle 10 of a divide
        @(negedge clk);
        bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.op = OP_IDLE;
        end
        check("flush pre busy", {63'd0, bus.busy}, 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy", {63'd0, bus.busy}, 64'd0);
        check("flush done", {63'd0, bus.done}, 64'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("flush no_done", 64'(n_done), 64'd0);
        check_hilo("flush hold", 32'd5, 32'h1999_9999);

        // mthi suppressed by flush
        move_op(OP_MTHI, 32'h0000_1234, 1'b1);
        check_hilo("mthi flushed", 32'd5, 32'h1999_9999);

        // mtlo presented while busy is ignored
        @(negedge clk);
        bus.op = OP_MULT; bus.a = 32'd2; bus.b = 32'd3;
        @(negedge clk);
        bus.op = OP_MTLO; bus.a = 32'h0000_DEAD;
        @(negedge clk);
        bus.op = OP_IDLE;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                n_done = 1;
                break;
            end
            @(negedge clk);
        end
        check("mtlo busy done_seen", 64'(n_done), 64'd1);
        check_hilo("mtlo while busy", 32'd0, 32'd6);

        // reset in the middle of a multiply
        move_op(OP_MTHI, 32'd5, 1'b0);
        @(negedge clk);
        bus.op = OP_MULT; bus.a = 32'd7; bus.b = 32'd9;
        @(negedge clk);
        bus.op = OP_IDLE;
        @(negedge clk);
        @(negedge clk);
        check("pre-reset busy", {63'd0, bus.busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_hilo("mid reset", 32'd0, 32'd0);
        check("mid reset busy", {63'd0, bus.busy}, 64'd0);
        check("mid reset done", {63'd0, bus.done}, 64'd0);
        reset = 1'b0;
        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("post reset no_done", 64'(n_done), 64'd0);
        check_hilo("post reset", 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
